uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 150 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   8N1 UART transmitter. A one-cycle TX_en in IDLE captures serial_out and
//   sends start bit, eight data bits LSB-first, then the stop bit. Each bit
//   lasts CLKS_PER_BIT cycles. Strobes that arrive while a frame is in flight
//   are dropped.
//
// Ports
//   sys_clk     in   system clock, rising edge
//   RST         in   asynchronous active-low reset
//   TX_en       in   send strobe, sampled only in IDLE
//   serial_out  in   [7:0] byte to send, captured on the accepting edge
//   tx          out  UART line, idles high
//   busy        out  high for the whole frame
//   done        out  one-cycle pulse in the last cycle of the stop bit
//
// state | meaning
// IDLE  | line high, waiting for TX_en
// START | driving the start bit (0)
// DATA  | driving shift register bit 0, eight bits LSB-first
// STOP  | driving the stop bit (1), done in its final cycle
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       sys_clk,
  input  logic       RST,
  input  logic       TX_en,
  input  logic [7:0] serial_out,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  // done is registered, so it is raised one cycle before the counter hits CNT_MAX
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CLKS_PER_BIT - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge sys_clk or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // tx/busy/done are registered, so each branch computes the value the line
  // must carry in the cycle after the coming edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (TX_en) begin
          shreg_d = serial_out;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            // next data bit is what lands in bit 0 after this shift
            tx_d  = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_PRE) done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLKS_PER_BIT = 4.
// Expected frames are written out by hand as {stop, D7..D0, start}.
module tb_uart_tx_serializer;

  localparam int N = 4;

  logic       sys_clk = 1'b0;
  logic       RST;
  logic       TX_en;
  logic [7:0] serial_out;
  logic       tx;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int e_first, e_second;

  uart_tx_serializer #(.CLKS_PER_BIT(N)) dut (
    .sys_clk   (sys_clk),
    .RST       (RST),
    .TX_en     (TX_en),
    .serial_out(serial_out),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic strobe(input logic [7:0] b);
    serial_out = b;
    TX_en      = 1'b1;
    tick();
    TX_en      = 1'b0;
  endtask

  // Called just after the accepting edge. Checks ncyc cycles of the frame;
  // optionally pulses TX_en with inj_b at cycle inj, or holds TX_en high.
  task automatic frame(input string tag, input logic [9:0] exp_f, input int ncyc,
                       input int inj, input logic [7:0] inj_b, input bit hold);
    int busy_n = 0;
    int done_n = 0;
    for (int i = 0; i < ncyc; i++) begin
      chk({tag, "_tx"}, 32'(tx), 32'(exp_f[i / N]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'(i == 10 * N - 1));
      busy_n += int'(busy);
      done_n += int'(done);
      TX_en      = hold || (i == inj);
      serial_out = (i == inj) ? inj_b : 8'($urandom);
      tick();
    end
    TX_en = hold;
    if (ncyc == 10 * N) begin
      chk({tag, "_busy_len"}, 32'(busy_n), 32'd40);
      chk({tag, "_done_cnt"}, 32'(done_n), 32'd1);
      chk({tag, "_end_busy"}, 32'(busy), 32'd0);
      chk({tag, "_end_tx"}, 32'(tx), 32'd1);
      chk({tag, "_end_done"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST        = 1'b0;
    TX_en      = 1'b0;
    serial_out = 8'h00;

    // reset, then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    RST = 1'b1;
    for (int i = 0; i < 100; i++) begin
      serial_out = 8'($urandom);
      tick();
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end

    // single byte 'A'
    strobe(8'h41);
    frame("h41", 10'b1010000010, 40, -1, 8'h00, 1'b0);
    tick();

    // newline, with 0xFF offered mid-frame (dropped)
    strobe(8'h0A);
    frame("h0A", 10'b1000010100, 40, 20, 8'hFF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("drop_idle_tx", 32'(tx), 32'd1);
      chk("drop_idle_busy", 32'(busy), 32'd0);
    end

    // back-to-back; a strobe in the done cycle is also dropped
    e_first = cyc + 1;
    strobe(8'h55);
    frame("h55", 10'b1010101010, 40, 39, 8'hC3, 1'b0);
    e_second = cyc + 1;
    strobe(8'hAA);
    chk("b2b_gap", 32'(e_second - e_first), 32'd41);
    frame("hAA", 10'b1101010100, 40, -1, 8'h00, 1'b0);
    tick();

    // reset during data bit 3 of 0x00
    strobe(8'h00);
    frame("h00_part", 10'b1000000000, 17, -1, 8'h00, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    chk("async_tx", 32'(tx), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("inrst_done", 32'(done), 32'd0);
      chk("inrst_tx", 32'(tx), 32'd1);
    end
    RST = 1'b1;
    tick();
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_done", 32'(done), 32'd0);
    strobe(8'h00);
    frame("h00", 10'b1000000000, 40, -1, 8'h00, 1'b0);
    tick();

    // held TX_en: accepts at E0 and E0+41
    serial_out = 8'h33;
    TX_en      = 1'b1;
    e_first    = cyc + 1;
    tick();
    frame("h33a", 10'b1001100110, 40, -1, 8'h00, 1'b1);
    serial_out = 8'h33;
    e_second   = cyc + 1;
    tick();
    chk("hold_gap", 32'(e_second - e_first), 32'd41);
    frame("h33b", 10'b1001100110, 40, -1, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("hold_idle_busy", 32'(busy), 32'd0);
      chk("hold_idle_tx", 32'(tx), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
